tmds_encoder_mc: RTL and testbench
==================================

Name: tmds_encoder_mc

Overview:
- Multi-channel, pipelined TMDS/HDMI channel encoder. Generalises the single-channel DVI encoder in four ways:
  - NCH parallel lanes.
  - Running disparity held internally per lane.
  - Valid-qualified 2-stage pipeline.
  - Two extra HDMI period modes: TERC4 data island and video guard band.
- Sits between the pixel/packet formatter and the 10:1 serialisers; one 10-bit symbol per lane per pixel clock.

Parameters:
- NCH, 3, number of TMDS lanes.
- CNT_W, 6, width of the signed per-lane disparity counter (two's complement).

Ports:
- clk  in  1  pixel clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- valid_in  in  1  input beat qualifier; a low cycle is a bubble.
- mode  in  2  period type: 00 control, 01 video, 10 TERC4 data island, 11 video guard band.
- data_in  in  8*NCH  video byte per lane; lane k uses [8k+7:8k].
- ctrl_in  in  2*NCH  {C1,C0} per lane; lane k uses [2k+1:2k].
- terc4_in  in  4*NCH  TERC4 nibble per lane; lane k uses [4k+3:4k].
- valid_out  out  1  output beat qualifier.
- data_out  out  10*NCH  encoded symbol per lane; bit 0 is transmitted first.
- disp_out  out  CNT_W*NCH  current running disparity per lane (debug/monitor).

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - valid_out=0; both pipeline valid bits = 0.
  - All disparity counters = 0; disp_out = 0.
  - Every lane's data_out = 1101010100 (control code 00).
- Latency is exactly 2 cycles: a beat accepted at edge N appears on data_out/valid_out after edge N+2. No backpressure.
- Stage 1, registered when valid_in=1 (per lane, video mode):
  - n1d = number of ones in D.
  - Use XNOR when n1d>4, or when n1d==4 and D[0]==0; otherwise use XOR.
  - q_m[0] = D[0]; q_m[i] = q_m[i-1] op D[i].
  - q_m[8] = 1 for XOR, 0 for XNOR.
  - Register q_m[8:0], n1q = ones(q_m[7:0]), n0q = 8-n1q, mode, ctrl, terc4.
- Stage 2, updates only when the stage-1 valid bit is 1. Video mode, per lane:
  - Case A, cnt==0 or n1q==n0q: out = {~q_m8, q_m8, q_m8 ? q_m[7:0] : ~q_m[7:0]}. cnt += (q_m8 ? n1q-n0q : n0q-n1q).
  - Case B, (cnt>0 and n1q>n0q) or (cnt<0 and n0q>n1q): out = {1, q_m8, ~q_m[7:0]}. cnt += 2*q_m8 + n0q - n1q.
  - Case C, otherwise: out = {0, q_m8, q_m[7:0]}. cnt += -2*(~q_m8) + n1q - n0q.
- Stage 2, non-video modes: cnt is forced to 0 on every valid non-video beat.
  - Control: 00→1101010100, 01→0010101011, 10→0101010100, 11→1010101011.
  - TERC4, nibble→symbol:
    - 0→1010011100, 1→1001100011, 2→1011100100, 3→1011100010
    - 4→0101110001, 5→0100011110, 6→0110001110, 7→0100111100
    - 8→1011001100, 9→0100111001, A→0110011100, B→1011000111
    - C→1010001110, D→1001110001, E→0101100011, F→1011000011
  - Guard band: even lane index→1011001100, odd lane index→0100110011.
- Bubbles: when the stage valid bit is 0, data_out and cnt hold their values and valid_out=0 that cycle. A bubble between two video beats must not alter the disparity sequence.
- Mode may change on any beat; every stage uses the mode captured with its own beat.
- Arithmetic:
  - All cnt math is signed at CNT_W bits.
  - |cnt| is bounded by the algorithm at ≤10, so no saturation logic is needed.
  - Counts n1q/n0q are 4-bit unsigned, zero-extended before signed use.
- Lanes are fully independent. The only shared signals are valid and mode.

Test Plan:
- Assert rst mid-stream with valid_in=1 → same-cycle valid_out=0, all lanes 1101010100, disp_out=0. After release, first output 2 cycles after the first valid_in.
- Video, lane 0, D=0x00 three beats from cnt=0:
  - Beat 1 → 0100000000, cnt=-8.
  - Beat 2 → 1111111111, cnt=+2.
  - Beat 3 → 0100000000, cnt=-6.
- Video, D=0xFF from cnt=0 → 1000000000, cnt=-8. The same sequence on lanes 1 and 2 with different data must be independent.
- Build disparity cnt=-8, then insert 3 bubble cycles, then D=0x00 → 1111111111, cnt=+2. valid_out is low during the bubbles and data_out is held.
- Control beat with ctrl=01 after nonzero cnt → 0010101011 and disp_out=0. The next video D=0x00 follows Case A (0100000000).
- TERC4 nibbles 0..F on all lanes → table values in order. Guard mode → lanes 0/1/2 = 1011001100/0100110011/1011001100. Alternating modes every beat are each encoded with their own captured mode.

Source files
------------

// File: rtl/tmds_encoder_mc.sv
// ---------------------------------------------------------------------------
// tmds_encoder_mc
//
// Multi-lane TMDS/HDMI channel encoder with a valid-qualified two-stage
// pipeline. Each lane turns one byte, control pair or TERC4 nibble per pixel
// clock into a 10-bit symbol for its 10:1 serialiser. Running disparity is
// kept per lane inside the encoder.
//
// Stage 1 does the transition-minimising XOR/XNOR chain and counts the ones
// of the result. Stage 2 picks the DC-balancing inversion (video) or looks up
// a fixed symbol (control, TERC4 data island, guard band) and registers it.
//
// Ports
//   clk        pixel clock, rising edge
//   rst        asynchronous active-high reset
//   valid_in   input beat qualifier (low = bubble)
//   mode       00 control, 01 video, 10 TERC4 data island, 11 guard band
//   data_in    video byte per lane, lane k at [8k+7:8k]
//   ctrl_in    {C1,C0} per lane, lane k at [2k+1:2k]
//   terc4_in   TERC4 nibble per lane, lane k at [4k+3:4k]
//   valid_out  output beat qualifier, two cycles behind valid_in
//   data_out   10-bit symbol per lane, lane k at [10k+9:10k], bit 0 sent first
//   disp_out   signed running disparity per lane, lane k at [CNT_W*k +: CNT_W]
// ---------------------------------------------------------------------------
module tmds_encoder_mc #(
    parameter int NCH   = 3,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    input  logic [1:0]           mode,
    input  logic [8*NCH-1:0]     data_in,
    input  logic [2*NCH-1:0]     ctrl_in,
    input  logic [4*NCH-1:0]     terc4_in,
    output logic                 valid_out,
    output logic [10*NCH-1:0]    data_out,
    output logic [CNT_W*NCH-1:0] disp_out
);

    typedef enum logic [1:0] {
        MODE_CTRL  = 2'b00,
        MODE_VIDEO = 2'b01,
        MODE_TERC4 = 2'b10,
        MODE_GUARD = 2'b11
    } mode_e;

    localparam logic [9:0]              CTRL0_SYM = 10'b1101010100;
    localparam logic signed [CNT_W-1:0] TWO       = CNT_W'(2);

    // Population count of a byte; result fits in 4 bits (0..8).
    function automatic logic [3:0] ones8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // Transition-minimising stage: bit 8 flags XOR (1) versus XNOR (0).
    function automatic logic [8:0] min_transition(input logic [7:0] d);
        logic [3:0] n1d;
        logic       use_xnor;
        logic [8:0] q;
        n1d      = ones8(d);
        use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !d[0]);
        q        = '0;
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = ~use_xnor;
        return q;
    endfunction

    function automatic logic [9:0] ctrl_symbol(input logic [1:0] c);
        logic [9:0] s;
        case (c)
            2'b00:   s = 10'b1101010100;
            2'b01:   s = 10'b0010101011;
            2'b10:   s = 10'b0101010100;
            default: s = 10'b1010101011;
        endcase
        return s;
    endfunction

    function automatic logic [9:0] terc4_symbol(input logic [3:0] t);
        logic [9:0] s;
        case (t)
            4'h0:    s = 10'b1010011100;
            4'h1:    s = 10'b1001100011;
            4'h2:    s = 10'b1011100100;
            4'h3:    s = 10'b1011100010;
            4'h4:    s = 10'b0101110001;
            4'h5:    s = 10'b0100011110;
            4'h6:    s = 10'b0110001110;
            4'h7:    s = 10'b0100111100;
            4'h8:    s = 10'b1011001100;
            4'h9:    s = 10'b0100111001;
            4'hA:    s = 10'b0110011100;
            4'hB:    s = 10'b1011000111;
            4'hC:    s = 10'b1010001110;
            4'hD:    s = 10'b1001110001;
            4'hE:    s = 10'b0101100011;
            default: s = 10'b1011000011;
        endcase
        return s;
    endfunction

    // Shared pipeline control: valid bits for both stages and the mode that
    // travels with each beat through stage 1.
    logic  s1_valid_d, s1_valid_q;
    logic  s2_valid_d, s2_valid_q;
    mode_e s1_mode_d,  s1_mode_q;

    // Stage 1 mode is only refreshed by real beats so a bubble can never
    // change how the held beat is interpreted.
    always_comb begin
        s1_valid_d = valid_in;
        s2_valid_d = s1_valid_q;
        s1_mode_d  = valid_in ? mode_e'(mode) : s1_mode_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_mode_q  <= MODE_CTRL;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_mode_q  <= s1_mode_d;
        end
    end

    assign valid_out = s2_valid_q;

    genvar k;
    generate
        for (k = 0; k < NCH; k++) begin : g_lane
            // Guard band alternates between even and odd lane numbers.
            localparam logic [9:0] GUARD_SYM =
                ((k % 2) == 0) ? 10'b1011001100 : 10'b0100110011;

            logic [8:0]              qm_d,    qm_q;
            logic [3:0]              n1q_d,   n1q_q;
            logic [1:0]              ctrl_d,  ctrl_q;
            logic [3:0]              terc4_d, terc4_q;
            logic [9:0]              sym_d,   sym_q;
            logic signed [CNT_W-1:0] cnt_d,   cnt_q;

            logic [3:0]              n0q;
            logic signed [CNT_W-1:0] diff;
            logic signed [CNT_W-1:0] bal_q8;
            logic signed [CNT_W-1:0] bal_nq8;

            // Stage 1: capture this lane's inputs and the minimised byte on
            // valid beats, otherwise hold.
            always_comb begin
                qm_d    = qm_q;
                n1q_d   = n1q_q;
                ctrl_d  = ctrl_q;
                terc4_d = terc4_q;
                if (valid_in) begin
                    qm_d    = min_transition(data_in[8*k +: 8]);
                    n1q_d   = ones8(qm_d[7:0]);
                    ctrl_d  = ctrl_in[2*k +: 2];
                    terc4_d = terc4_in[4*k +: 4];
                end
            end

            // Stage 2: DC balancing for video, table symbols otherwise.
            // diff is n1q-n0q as a signed value; the bal_* terms are the
            // +/-2 corrections that depend on which chain stage 1 used.
            always_comb begin
                n0q     = 4'd8 - n1q_q;
                diff    = signed'(CNT_W'(n1q_q)) - signed'(CNT_W'(n0q));
                bal_q8  = qm_q[8] ? TWO : '0;
                bal_nq8 = qm_q[8] ? '0  : TWO;
                sym_d   = sym_q;
                cnt_d   = cnt_q;
                if (s1_valid_q) begin
                    case (s1_mode_q)
                        MODE_VIDEO: begin
                            if ((cnt_q == '0) || (n1q_q == n0q)) begin
                                sym_d = {~qm_q[8], qm_q[8],
                                         qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
                                cnt_d = qm_q[8] ? (cnt_q + diff) : (cnt_q - diff);
                            // cnt is known non-zero here, so its sign bit
                            // alone separates positive from negative.
                            end else if ((!cnt_q[CNT_W-1] && (n1q_q > n0q)) ||
                                         ( cnt_q[CNT_W-1] && (n0q > n1q_q))) begin
                                sym_d = {1'b1, qm_q[8], ~qm_q[7:0]};
                                cnt_d = cnt_q + bal_q8 - diff;
                            end else begin
                                sym_d = {1'b0, qm_q[8], qm_q[7:0]};
                                cnt_d = cnt_q - bal_nq8 + diff;
                            end
                        end
                        MODE_TERC4: begin
                            sym_d = terc4_symbol(terc4_q);
                            cnt_d = '0;
                        end
                        MODE_GUARD: begin
                            sym_d = GUARD_SYM;
                            cnt_d = '0;
                        end
                        default: begin
                            sym_d = ctrl_symbol(ctrl_q);
                            cnt_d = '0;
                        end
                    endcase
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    qm_q    <= '0;
                    n1q_q   <= '0;
                    ctrl_q  <= '0;
                    terc4_q <= '0;
                    sym_q   <= CTRL0_SYM;
                    cnt_q   <= '0;
                end else begin
                    qm_q    <= qm_d;
                    n1q_q   <= n1q_d;
                    ctrl_q  <= ctrl_d;
                    terc4_q <= terc4_d;
                    sym_q   <= sym_d;
                    cnt_q   <= cnt_d;
                end
            end

            assign data_out[10*k +: 10]       = sym_q;
            assign disp_out[CNT_W*k +: CNT_W] = cnt_q;
        end
    endgenerate

endmodule

// File: tb/tb_tmds_encoder_mc.sv
// ---------------------------------------------------------------------------
// tb_tmds_encoder_mc
//
// Table-driven bench for the three-lane TMDS encoder. A list of beats with
// hand-computed symbols and disparities is streamed back to back; each row's
// outputs are compared two cycles after it is driven. Hand-written sequences
// cover asynchronous reset mid-stream and the latency after reset release.
// ---------------------------------------------------------------------------
module tb_tmds_encoder_mc;

    localparam int NCH   = 3;
    localparam int CNT_W = 6;

    localparam logic [1:0] M_CTRL  = 2'b00;
    localparam logic [1:0] M_VIDEO = 2'b01;
    localparam logic [1:0] M_TERC4 = 2'b10;
    localparam logic [1:0] M_GUARD = 2'b11;

    localparam logic [9:0] S_C00   = 10'b1101010100;
    localparam logic [9:0] S_C01   = 10'b0010101011;
    localparam logic [9:0] S_C10   = 10'b0101010100;
    localparam logic [9:0] S_C11   = 10'b1010101011;
    localparam logic [9:0] S_GEVEN = 10'b1011001100;
    localparam logic [9:0] S_GODD  = 10'b0100110011;

    logic                 clk;
    logic                 rst;
    logic                 valid_in;
    logic [1:0]           mode;
    logic [8*NCH-1:0]     data_in;
    logic [2*NCH-1:0]     ctrl_in;
    logic [4*NCH-1:0]     terc4_in;
    logic                 valid_out;
    logic [10*NCH-1:0]    data_out;
    logic [CNT_W*NCH-1:0] disp_out;

    typedef struct {
        logic        valid;
        logic [1:0]  mode;
        logic [23:0] data;
        logic [5:0]  ctrl;
        logic [11:0] terc4;
        logic        exp_valid;
        logic [29:0] exp_data;
        logic [17:0] exp_disp;
    } vec_t;

    vec_t       vecs[$];
    logic [9:0] terc4_tab[16];
    int         total;
    int         passed;

    tmds_encoder_mc #(.NCH(NCH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .mode      (mode),
        .data_in   (data_in),
        .ctrl_in   (ctrl_in),
        .terc4_in  (terc4_in),
        .valid_out (valid_out),
        .data_out  (data_out),
        .disp_out  (disp_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pack three lane symbols as {lane2, lane1, lane0}.
    function automatic logic [29:0] sym3(input logic [9:0] l0, input logic [9:0] l1,
                                         input logic [9:0] l2);
        return {l2, l1, l0};
    endfunction

    // Pack three signed disparities, truncated to 6-bit two's complement.
    function automatic logic [17:0] disp3(input int a, input int b, input int c);
        logic [5:0] x, y, z;
        x = a[5:0];
        y = b[5:0];
        z = c[5:0];
        return {z, y, x};
    endfunction

    task automatic addVec(input logic v, input logic [1:0] m, input logic [23:0] d,
                          input logic [5:0] c, input logic [11:0] t, input logic ev,
                          input logic [29:0] ed, input logic [17:0] edisp);
        vec_t r;
        r.valid = v;  r.mode = m;  r.data = d;  r.ctrl = c;  r.terc4 = t;
        r.exp_valid = ev;  r.exp_data = ed;  r.exp_disp = edisp;
        vecs.push_back(r);
    endtask

    task automatic applyStimulus(input vec_t r);
        valid_in = r.valid;
        mode     = r.mode;
        data_in  = r.data;
        ctrl_in  = r.ctrl;
        terc4_in = r.terc4;
    endtask

    task automatic driveIdle();
        valid_in = 1'b0;
        mode     = M_CTRL;
        data_in  = '0;
        ctrl_in  = '0;
        terc4_in = '0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic checkOutput(input string tag, input logic ev, input logic [29:0] ed,
                               input logic [17:0] edisp);
        check({tag, " valid_out"}, {31'd0, valid_out}, {31'd0, ev});
        check({tag, " data_out"},  {2'd0, data_out},   {2'd0, ed});
        check({tag, " disp_out"},  {14'd0, disp_out},  {14'd0, edisp});
    endtask

    initial begin
        vec_t r;
        int   n;
        total  = 0;
        passed = 0;

        terc4_tab = '{10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
                      10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
                      10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000111,
                      10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

        // Video: lane0 0x00, lane1 0xFF, lane2 0x01, three beats from zero.
        for (int b = 0; b < 3; b++) begin
            case (b)
                0: addVec(1, M_VIDEO, 24'h01FF00, 6'h0, 12'h0, 1,
                          sym3(10'b0100000000, 10'b1000000000, 10'b0111111111),
                          disp3(-8, -8, 8));
                1: addVec(1, M_VIDEO, 24'h01FF00, 6'h0, 12'h0, 1,
                          sym3(10'b1111111111, 10'b0011111111, 10'b1100000000),
                          disp3(2, -2, 2));
                default: addVec(1, M_VIDEO, 24'h01FF00, 6'h0, 12'h0, 1,
                          sym3(10'b0100000000, 10'b0011111111, 10'b1100000000),
                          disp3(-6, 4, -4));
            endcase
        end
        // Control 01 clears the nonzero disparities; video 0x00 then takes case A.
        addVec(1, M_CTRL,  24'h000000, 6'b010101, 12'h0, 1, sym3(S_C01, S_C01, S_C01), disp3(0, 0, 0));
        addVec(1, M_VIDEO, 24'h000000, 6'h0, 12'h0, 1,
               sym3(10'b0100000000, 10'b0100000000, 10'b0100000000), disp3(-8, -8, -8));
        // Three bubbles carrying junk inputs: outputs and disparity must hold.
        for (int b = 0; b < 3; b++) begin
            addVec(0, M_VIDEO, 24'hFFFFFF, 6'h3F, 12'hFFF, 0,
                   sym3(10'b0100000000, 10'b0100000000, 10'b0100000000), disp3(-8, -8, -8));
        end
        addVec(1, M_VIDEO, 24'h000000, 6'h0, 12'h0, 1,
               sym3(10'b1111111111, 10'b1111111111, 10'b1111111111), disp3(2, 2, 2));
        // TERC4: lane k carries nibble (i+k) mod 16, sweeping every code per lane.
        for (int i = 0; i < 16; i++) begin
            addVec(1, M_TERC4, 24'h0, 6'h0,
                   {4'((i + 2) % 16), 4'((i + 1) % 16), 4'(i)}, 1,
                   sym3(terc4_tab[i], terc4_tab[(i + 1) % 16], terc4_tab[(i + 2) % 16]),
                   disp3(0, 0, 0));
        end
        addVec(1, M_GUARD, 24'h0, 6'h0, 12'h0, 1, sym3(S_GEVEN, S_GODD, S_GEVEN), disp3(0, 0, 0));
        // Mode changes every beat.
        addVec(1, M_VIDEO, 24'h000000, 6'h0, 12'h0, 1,
               sym3(10'b0100000000, 10'b0100000000, 10'b0100000000), disp3(-8, -8, -8));
        addVec(1, M_CTRL, 24'hFFFFFF, 6'b111000, 12'h0, 1, sym3(S_C00, S_C10, S_C11), disp3(0, 0, 0));
        addVec(1, M_TERC4, 24'h0, 6'h0, 12'h555, 1,
               sym3(10'b0100011110, 10'b0100011110, 10'b0100011110), disp3(0, 0, 0));
        addVec(1, M_GUARD, 24'h0, 6'h0, 12'h0, 1, sym3(S_GEVEN, S_GODD, S_GEVEN), disp3(0, 0, 0));
        addVec(1, M_VIDEO, 24'h000000, 6'h0, 12'h0, 1,
               sym3(10'b0100000000, 10'b0100000000, 10'b0100000000), disp3(-8, -8, -8));
        addVec(1, M_VIDEO, 24'h000000, 6'h0, 12'h0, 1,
               sym3(10'b1111111111, 10'b1111111111, 10'b1111111111), disp3(2, 2, 2));

        // Reset state.
        rst = 1'b1;
        driveIdle();
        #3;
        checkOutput("reset", 1'b0, sym3(S_C00, S_C00, S_C00), disp3(0, 0, 0));
        @(posedge clk);
        #1 rst = 1'b0;

        // Stream the table; row i is checked two edges after it is driven.
        n = vecs.size();
        for (int i = 0; i < n + 2; i++) begin
            @(posedge clk);
            #1;
            if (i >= 2) checkOutput($sformatf("row%0d", i - 2), vecs[i - 2].exp_valid,
                                    vecs[i - 2].exp_data, vecs[i - 2].exp_disp);
            if (i < n) applyStimulus(vecs[i]);
            else       driveIdle();
        end

        // Mid-stream asynchronous reset with valid_in held high.
        r.valid = 1;  r.mode = M_VIDEO;  r.data = 24'h000000;  r.ctrl = '0;  r.terc4 = '0;
        @(posedge clk);
        #1 applyStimulus(r);
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("prereset", 1'b1,
                    sym3(10'b0100000000, 10'b0100000000, 10'b0100000000), disp3(-6, -6, -6));
        #2 rst = 1'b1;
        #1;
        checkOutput("async_reset", 1'b0, sym3(S_C00, S_C00, S_C00), disp3(0, 0, 0));
        @(posedge clk);
        #1 rst = 1'b0;
        driveIdle();

        // First beat after release appears exactly two edges later.
        r.data = 24'hFFFFFF;
        @(posedge clk);
        #1 applyStimulus(r);
        @(posedge clk);
        #1;
        driveIdle();
        checkOutput("post_reset_lat1", 1'b0, sym3(S_C00, S_C00, S_C00), disp3(0, 0, 0));
        @(posedge clk);
        #1;
        checkOutput("post_reset_lat2", 1'b1,
                    sym3(10'b1000000000, 10'b1000000000, 10'b1000000000), disp3(-8, -8, -8));
        @(posedge clk);
        #1;
        checkOutput("post_reset_idle", 1'b0,
                    sym3(10'b1000000000, 10'b1000000000, 10'b1000000000), disp3(-8, -8, -8));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
